// File: rtl/cache_1b_pkg.sv
// cache_1b_pkg: shared geometry, address field positions and main-memory init contents
// for the cache_1b write-through, 2-way set-associative cache.
package cache_1b_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned WORD_W          = 2;   // word-in-block field width
  localparam int unsigned SET_W           = 2;
  localparam int unsigned TAG_W           = 4;
  localparam int unsigned WORD_LSB        = 2;
  localparam int unsigned SET_LSB         = 4;
  localparam int unsigned TAG_LSB         = 6;

  localparam int unsigned NUM_SETS        = 4;
  localparam int unsigned NUM_WAYS        = 2;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned MEM_WORDS       = 256;
  localparam int unsigned MEM_AW          = 8;   // address[9:2]
  localparam int unsigned BLOCK_AW        = 6;   // address[9:4]

  localparam logic [DATA_W-1:0] MEM_INIT_0   = 32'h0000_3cc3;
  localparam logic [DATA_W-1:0] MEM_INIT_128 = 32'h0000_0ccc;
  localparam logic [DATA_W-1:0] MEM_INIT_192 = 32'h0000_00c3;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [WORDS_PER_BLOCK-1:0] block_t;

  function automatic word_t memInit(input int unsigned idx);
    case (idx)
      0:       memInit = MEM_INIT_0;
      128:     memInit = MEM_INIT_128;
      192:     memInit = MEM_INIT_192;
      default: memInit = '0;
    endcase
  endfunction

endpackage

// File: rtl/cache_1b_if.sv
// cache_1b_if: processor-side access bus of cache_1b.
//   req/isRead/address/writeData : request, driven by the requester (master)
//   readData/isHit/resp_valid    : registered response, driven by the cache (slave)
interface cache_1b_if;
  import cache_1b_pkg::*;

  logic              req;
  logic              isRead;
  logic [ADDR_W-1:0] address;
  word_t             writeData;
  word_t             readData;
  logic              isHit;
  logic              resp_valid;

  modport master (
    output req, isRead, address, writeData,
    input  readData, isHit, resp_valid
  );

  modport slave (
    input  req, isRead, address, writeData,
    output readData, isHit, resp_valid
  );

endinterface

// File: rtl/cache_1b_mem.sv
// cache_1b_mem: 256 x 32 main memory.
//   clk, rst_n : clock, async active-low reset (restores init contents)
//   we, wAddr, wData : synchronous single-word write port
//   blockAddr, block : combinational 4-word block read port
module cache_1b_mem
  import cache_1b_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [MEM_AW-1:0]   wAddr,
  input  word_t               wData,
  input  logic [BLOCK_AW-1:0] blockAddr,
  output block_t              block
);

  word_t mem [MEM_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= memInit(i);
    end else if (we) begin
      mem[wAddr] <= wData;
    end
  end

  always_comb begin
    block = '0;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      block[w] = mem[{blockAddr, WORD_W'(w)}];
    end
  end

endmodule

// File: rtl/cache_1b.sv
// cache_1b: write-through 2-way set-associative cache (4 sets, 4-word blocks) with its
// backing main memory. Single-cycle refill, 1-cycle registered response.
//   clk, rst_n : clock, async active-low reset
//   bus        : cache_1b_if.slave access bus (request in, readData/isHit/resp_valid out)
// Build option: define CACHE_1B_WRITE_ALLOCATE_EN to refill on write misses;
// default is no-write-allocate.
module cache_1b
  import cache_1b_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  cache_1b_if.slave    bus
);

`ifdef CACHE_1B_WRITE_ALLOCATE_EN
  localparam bit WriteAllocate = 1'b1;
`else
  localparam bit WriteAllocate = 1'b0;
`endif

  logic             valid_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  block_t           data_q  [NUM_SETS][NUM_WAYS];
  logic             lru_q   [NUM_SETS];

  word_t readData_q;
  logic  isHit_q;
  logic  respValid_q;

  logic [WORD_W-1:0] word;
  logic [SET_W-1:0]  set;
  logic [TAG_W-1:0]  tag;
  logic              unusedByteBits;

  assign word           = bus.address[WORD_LSB +: WORD_W];
  assign set            = bus.address[SET_LSB +: SET_W];
  assign tag            = bus.address[TAG_LSB +: TAG_W];
  assign unusedByteBits = ^bus.address[1:0];

  block_t memBlock;
  logic   memWe;

  cache_1b_mem mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (memWe),
    .wAddr     (bus.address[WORD_LSB +: MEM_AW]),
    .wData     (bus.writeData),
    .blockAddr (bus.address[SET_LSB +: BLOCK_AW]),
    .block     (memBlock)
  );

  logic [NUM_WAYS-1:0] hitVec;
  logic   hit, hitWay, victim, doFill, doHitWrite, touch, usedWay;
  block_t fillBlock;
  word_t  respData;

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      hitVec[w] = valid_q[set][w] && (tag_q[set][w] == tag);
    end
    hit    = |hitVec;
    hitWay = hitVec[1];
    // First invalid way (way 0 preferred), else the LRU-named way.
    if (!valid_q[set][0])      victim = 1'b0;
    else if (!valid_q[set][1]) victim = 1'b1;
    else                       victim = lru_q[set];

    memWe      = bus.req && !bus.isRead;
    doFill     = bus.req && !hit && (bus.isRead || WriteAllocate);
    doHitWrite = bus.req && hit && !bus.isRead;
    touch      = bus.req && (hit || doFill);
    usedWay    = hit ? hitWay : victim;

    // Refill comes from memory before this cycle's write lands, so merge the write in.
    fillBlock = memBlock;
    if (!bus.isRead) fillBlock[word] = bus.writeData;

    if (!bus.isRead)  respData = bus.writeData;
    else if (hit)     respData = data_q[set][hitWay][word];
    else              respData = memBlock[word];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
        end
      end
    end else begin
      if (doFill) begin
        valid_q[set][victim] <= 1'b1;
        tag_q[set][victim]   <= tag;
        data_q[set][victim]  <= fillBlock;
      end else if (doHitWrite) begin
        data_q[set][hitWay][word] <= bus.writeData;
      end
      if (touch) lru_q[set] <= ~usedWay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respValid_q <= 1'b0;
      readData_q  <= '0;
      isHit_q     <= 1'b0;
    end else begin
      respValid_q <= bus.req;
      if (bus.req) begin
        readData_q <= respData;
        isHit_q    <= hit;
      end
    end
  end

  assign bus.readData   = readData_q;
  assign bus.isHit      = isHit_q;
  assign bus.resp_valid = respValid_q;

endmodule

// File: tb/tb_cache_1b.sv
// tb_cache_1b: scoreboard bench for cache_1b. Requests are driven on the falling edge and
// their expected responses queued; a checker pops and compares each response.
module tb_cache_1b;

`ifdef CACHE_1B_WRITE_ALLOCATE_EN
  localparam bit WA = 1'b1;
`else
  localparam bit WA = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_1b_if bus ();

  cache_1b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        hit;
    string       name;
  } exp_t;

  exp_t        expQ [$];
  logic [31:0] modelMem [256];
  int          tests = 0;
  int          errors = 0;

  function automatic void modelReset();
    for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;
    modelMem[0]   = 32'h0000_3cc3;
    modelMem[128] = 32'h0000_0ccc;
    modelMem[192] = 32'h0000_00c3;
  endfunction

  // Scoreboard checker.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      exp_t e;
      tests++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1, required no response");
      end else begin
        e = expQ.pop_front();
        if (bus.readData !== e.data || bus.isHit !== e.hit) begin
          errors++;
          $display("FAIL %s: got data=%08h hit=%b, required data=%08h hit=%b",
                   e.name, bus.readData, bus.isHit, e.data, e.hit);
        end
      end
    end
  end

  task automatic access(input logic rd, input logic [9:0] a, input logic [31:0] wd,
                        input logic expHit, input string nm);
    exp_t e;
    @(negedge clk);
    bus.req       = 1'b1;
    bus.isRead    = rd;
    bus.address   = a;
    bus.writeData = wd;
    e.data = rd ? modelMem[a[9:2]] : wd;
    e.hit  = expHit;
    e.name = nm;
    if (!rd) modelMem[a[9:2]] = wd;
    expQ.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.isRead = 1'b1; bus.address = '0; bus.writeData = '0;
    modelReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.readData !== 32'h0 || bus.isHit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%08h hit=%b, required 0/0/0",
               bus.resp_valid, bus.readData, bus.isHit);
    end
    tests++;
    if (dut.mem.mem[0] !== 32'h3cc3 || dut.mem.mem[128] !== 32'hccc ||
        dut.mem.mem[192] !== 32'hc3 || dut.mem.mem[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: got %08h %08h %08h %08h, required 3cc3 ccc c3 0",
               dut.mem.mem[0], dut.mem.mem[128], dut.mem.mem[192], dut.mem.mem[1]);
    end
  endtask

  task automatic test_read_miss_hit();
    access(1'b1, 10'h000, '0, 1'b0, "read0_miss");
    access(1'b1, 10'h000, '0, 1'b1, "read0_hit");
    idle();
  endtask

  task automatic test_write_hit();
    access(1'b0, 10'h000, 32'h0000_00ff, 1'b1, "write0_hit");
    idle();
    tests++;
    if (dut.mem.mem[0] !== 32'hff) begin
      errors++;
      $display("FAIL write_through: got mem[0]=%08h, required 000000ff", dut.mem.mem[0]);
    end
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.readData !== 32'hff || bus.isHit !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: got valid=%b data=%08h hit=%b, required 0/000000ff/1",
               bus.resp_valid, bus.readData, bus.isHit);
    end
    access(1'b1, 10'h000, '0, 1'b1, "read0_after_write");
    idle();
  endtask

  task automatic test_lru_evict();
    access(1'b1, 10'h200, '0, 1'b0, "read200_miss");
    access(1'b1, 10'h000, '0, 1'b1, "read0_hit_2way");
    access(1'b1, 10'h300, '0, 1'b0, "read300_evict200");
    access(1'b1, 10'h200, '0, 1'b0, "read200_refill");
    access(1'b1, 10'h300, '0, 1'b1, "read300_still_hit");
    idle();
    tests++;
    if (dut.mem.mem[0] !== 32'hff) begin
      errors++;
      $display("FAIL no_writeback: got mem[0]=%08h, required 000000ff", dut.mem.mem[0]);
    end
  endtask

  task automatic test_write_miss();
    access(1'b0, 10'h010, 32'h1234_5678, 1'b0, "write010_miss");
    idle();
    tests++;
    if (dut.mem.mem[4] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_miss_mem: got mem[4]=%08h, required 12345678", dut.mem.mem[4]);
    end
    access(1'b1, 10'h010, '0, WA, "read010_after_wmiss");
    access(1'b1, 10'h010, '0, 1'b1, "read010_again");
    idle();
  endtask

  task automatic test_back_to_back();
    access(1'b1, 10'h0a0, '0, 1'b0, "b2b_fill");
    for (int i = 1; i < 4; i++) access(1'b1, 10'(10'h0a0 + 4 * i), '0, 1'b1, "b2b_read0");
    for (int i = 0; i < 4; i++)
      access(1'b0, 10'(10'h0a0 + 4 * i), 32'h1111_1111 * (i + 1), 1'b1, "b2b_write");
    for (int i = 3; i >= 0; i--) access(1'b1, 10'(10'h0a0 + 4 * i), '0, 1'b1, "b2b_readback");
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req = 1'b1; bus.isRead = 1'b0; bus.address = 10'h000; bus.writeData = 32'hdead_beef;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req = 1'b0;
    modelReset();
    #1;
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.readData !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: got valid=%b data=%08h, required 0/00000000",
               bus.resp_valid, bus.readData);
    end
    tests++;
    if (dut.mem.mem[0] !== 32'h3cc3 || dut.mem.mem[4] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_reinit: got mem[0]=%08h mem[4]=%08h, required 3cc3/0",
               dut.mem.mem[0], dut.mem.mem[4]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 10'h000, '0, 1'b0, "read0_after_reset");
    access(1'b1, 10'h010, '0, 1'b0, "read010_after_reset");
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_lru_evict();
    test_write_miss();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: got %0d responses outstanding, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
